// File: rtl/multdiv_seq_ctrl.sv
// rtl/multdiv_seq_ctrl.sv - sequencer for the shared multi-cycle multiplier/divider
//
// Detects mul/div in the D/X latch, fires a one-cycle start pulse at the unit,
// stalls the front of the pipeline until the result arrives, a timeout expires
// or a flush aborts, then presents the result to the X-stage mux for one cycle.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   ir_dx, flush        D/X instruction and branch/jump flush
//   md_result/ready/exception  multdiv unit response
//   ctrl_mult/ctrl_div  one-cycle start pulses
//   stall               holds PC, F/D and D/X latches
//   md_sel, res_out, exc, rstatus_code  one-cycle result presentation
//   busy                controller not idle
//
// Optional build macro MDCTRL_PERF_EN adds saturating perf_stall_cycles and
// perf_timeouts counters.

module multdiv_seq_ctrl #(
  parameter int MAX_CYCLES  = 40,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_dx,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        md_sel,
  output logic [31:0] res_out,
  output logic        exc,
  output logic [31:0] rstatus_code,
  output logic        busy
`ifdef MDCTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_timeouts
`endif
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           op_div_q, op_div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    res_q, res_d;
  logic           exc_q, exc_d;
  logic [31:0]    rstatus_q, rstatus_d;

  logic           is_mul, is_div, md_instr;
  logic [CW-1:0]  cnt_inc;
  logic [31:0]    exc_code;
  logic           timeout_evt;

  assign is_mul   = (ir_dx[31:27] == 5'b00000) && (ir_dx[6:2] == 5'b00110);
  assign is_div   = (ir_dx[31:27] == 5'b00000) && (ir_dx[6:2] == 5'b00111);
  assign md_instr = is_mul | is_div;

  // cnt_inc is the number of WAIT cycles including the current one, so the
  // timeout fires in the MAX_CYCLES-th WAIT cycle.
  assign cnt_inc  = cnt_q + 1'b1;
  assign exc_code = op_div_q ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MUL);

  always_comb begin
    state_d     = state_q;
    op_div_d    = op_div_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    // exc/rstatus are only meaningful in DONE, so they drop back to zero
    // whenever a new capture is not happening.
    exc_d       = 1'b0;
    rstatus_d   = '0;
    timeout_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_instr && !flush) begin
          op_div_d = is_div;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          res_d     = md_result;
          exc_d     = md_exception;
          rstatus_d = md_exception ? exc_code : 32'd0;
          state_d   = S_DONE;
        end else if (cnt_inc == CW'(MAX_CYCLES)) begin
          res_d       = '0;
          exc_d       = 1'b1;
          rstatus_d   = exc_code;
          timeout_evt = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_div_q  <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      rstatus_q <= '0;
    end else begin
      state_q   <= state_d;
      op_div_q  <= op_div_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      rstatus_q <= rstatus_d;
    end
  end

  assign ctrl_mult    = (state_q == S_START) && !op_div_q;
  assign ctrl_div     = (state_q == S_START) &&  op_div_q;
  assign md_sel       = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign res_out      = res_q;
  assign exc          = exc_q;
  assign rstatus_code = rstatus_q;

  // Stall rises in the same cycle the mul/div shows up in D/X; it is held low
  // while reset is asserted so every output is quiet during reset.
  assign stall = reset &&
                 (((state_q == S_IDLE) && md_instr && !flush) ||
                  (state_q == S_START) || (state_q == S_WAIT));

`ifdef MDCTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_to_q, perf_to_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_to_d    = perf_to_q;
    if (stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 1'b1;
    if (timeout_evt && (perf_to_q != '1)) perf_to_d = perf_to_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_to_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_to_q    <= perf_to_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_timeouts     = perf_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_evt;
`endif

endmodule

// File: doc/multdiv_seq_ctrl.md
Name: multdiv_seq_ctrl

Overview:
- Controller that sequences the shared multi-cycle multiplier/divider for the 5-stage pipeline.
- Detects mul/div in the D/X latch and launches the unit with a one-cycle control pulse.
- Stalls PC and upstream latches (feeds the next-PC stall input) until the result is ready, a timeout expires, or a flush aborts.
- Presents the result and exception status to the X-stage result mux for one cycle.

Parameters:
- MAX_CYCLES, 40: WAIT cycles before a timeout exception; counter width is clog2(MAX_CYCLES+1).
- RSTATUS_MUL, 4: rstatus code for a mul exception or timeout.
- RSTATUS_DIV, 5: rstatus code for a div exception or timeout.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ir_dx  in  32  instruction in the D/X latch
- flush  in  1  branch/jump flush (flushJ | flushB)
- md_result  in  32  multdiv data_result
- md_ready  in  1  multdiv data_resultRDY
- md_exception  in  1  multdiv data_exception
- ctrl_mult  out  1  one-cycle start pulse for mul
- ctrl_div  out  1  one-cycle start pulse for div
- stall  out  1  holds PC, F/D and D/X latches
- md_sel  out  1  X-stage mux selects res_out
- res_out  out  32  latched result
- exc  out  1  exception/timeout flag, valid while md_sel
- rstatus_code  out  32  code to write to r30 when exc
- busy  out  1  state is not IDLE

Behaviour:
- Decode: is_mul = (ir_dx[31:27]==00000) & (ir_dx[6:2]==00110); is_div = (ir_dx[31:27]==00000) & (ir_dx[6:2]==00111).
- Reset (async, reset==0): state IDLE, op flag 0, counter 0, res_out 0, exc 0, rstatus_code 0, and all pulse/flag outputs 0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If (is_mul|is_div) & ~flush: latch op type (mul=0, div=1), go to START.
  - Otherwise stay in IDLE.
- START:
  - Exactly one cycle with ctrl_mult=1 (mul) or ctrl_div=1 (div), decoded from the registered state.
  - Clear the counter, go to WAIT.
- WAIT, evaluated each cycle in this priority order:
  1. flush: go to IDLE; no result, no exc.
  2. md_ready: capture md_result into res_out and md_exception into exc, go to DONE.
  3. counter==MAX_CYCLES: res_out=0, exc=1, go to DONE.
  4. Otherwise increment the counter.
- DONE:
  - md_sel=1 for exactly one cycle, stall=0 so the D/X instruction advances into X/M.
  - If exc, rstatus_code = RSTATUS_MUL or RSTATUS_DIV per op type; otherwise 0.
  - Always go to IDLE; the next instruction is evaluated in IDLE on the following cycle.
- stall is combinational: (IDLE & (is_mul|is_div) & ~flush) | START | WAIT. It rises in the same cycle the mul/div appears in D/X.
- Total stall cycles for an N-cycle multdiv (RDY in the Nth WAIT cycle): N+2. The result is consumed in the cycle after the last stall.
- flush in START: ignore the pulse's effect and go to IDLE. The start pulse still fires, the unit is later restarted by the next pulse, and md_ready arriving in IDLE is ignored.
- Back-to-back mul/div: the second is detected in IDLE after DONE; no pulse overlap.
- md_ready in the same cycle as a timeout: md_ready wins.
- Reset mid-operation: immediately return to IDLE with all outputs 0.

Optional Feature:
- MDCTRL_PERF_EN defined:
  - Adds output perf_stall_cycles (32 bits), counting cycles with stall=1, and output perf_timeouts (16 bits), counting timeout events.
  - Both saturate at all-ones and clear on reset.
- Undefined: neither port nor their counters exist; behaviour is otherwise identical.

Test Plan:
- mul in D/X, md_ready in the 3rd WAIT cycle with result 0x0000002A → stall high 5 cycles; ctrl_mult high exactly 1 cycle; next cycle md_sel=1, res_out=0x2A, exc=0, rstatus_code=0.
- div with md_exception=1 at RDY → DONE: exc=1, rstatus_code=5, ctrl_div pulsed once, ctrl_mult never asserted.
- md_ready never asserted (mul) → exactly 40 WAIT cycles, then DONE with exc=1, rstatus_code=4, res_out=0.
- flush asserted in the 2nd WAIT cycle → next cycle IDLE, stall=0, md_sel never asserted; a later md_ready pulse is ignored.
- mul followed directly by div → two separate START pulses (ctrl_mult then ctrl_div) separated by DONE and IDLE cycles; each result is presented with md_sel for 1 cycle.
- reset driven low during WAIT → asynchronously IDLE with all outputs 0. After release, a non-multdiv ir_dx (add) produces no stall.
